// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predictor / resolver slice.
// Holds the resolver state encoding, the predictor counter encoding and PC helpers.
package branch_pkg;

    localparam int PC_W       = 32;
    localparam int INSN_BYTES = 4;

    typedef enum logic {
        RES_IDLE = 1'b0,
        RES_PEND = 1'b1
    } res_state_e;

    // 2-bit saturating counter encoding shared with the gshare predictor
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b11,
        ST  = 2'b10
    } bp_cnt_e;

    typedef struct packed {
        logic            valid;
        logic            pred;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
    } de_entry_t;

    typedef struct packed {
        logic            valid;
        logic            pred;
        logic            actual;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
    } em_entry_t;

    function automatic logic [PC_W-1:0] fall_through(input logic [PC_W-1:0] pc,
                                                     input logic            delay_slot);
        return pc + (delay_slot ? PC_W'(2 * INSN_BYTES) : PC_W'(INSN_BYTES));
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Predictor update strobes and front-end redirect handshake of the branch resolver.
// master = branch_resolve, slave = predictor / fetch PC mux.
interface branch_resolve_if;
    import branch_pkg::*;

    logic            branchM;
    logic            actual_takeM;
    logic [PC_W-1:0] pcM;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [PC_W-1:0] redirect_pc;

    modport master (
        output branchM, actual_takeM, pcM, redirect_valid, redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  branchM, actual_takeM, pcM, redirect_valid, redirect_pc,
        output redirect_ready
    );

endinterface

// File: rtl/bp_stage_reg.sv
// Generic pipeline register with priority rst > flush > load-when-not-stalled.
// A flush or reset clears every bit, so a cleared entry always reads invalid.
module bp_stage_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // next-value selection
    always_comb begin
        data_d = data_q;
        if (rst) begin
            data_d = '0;
        end else if (flush) begin
            data_d = '0;
        end else if (!stall) begin
            data_d = d;
        end else begin
            data_d = data_q;
        end
    end

    // storage
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/branch_resolve.sv
// M-stage branch resolver: carries D-stage predictions to M, updates the predictor
// and raises a front-end redirect on mispredict. Optional counters: BRANCH_RESOLVE_PERF_CNT_EN.
module branch_resolve
    import branch_pkg::*;
#(
    parameter bit DELAY_SLOT = 1'b0,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branchD,
    input  logic             pred_takeD,
    input  logic [PC_W-1:0]  pcD,
    input  logic [PC_W-1:0]  targetD,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             stallM,
    input  logic             flushM,
    input  logic             actual_takeE,
    output logic             mispredM,
    output logic             flush_front,
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
`endif
    branch_resolve_if.master bus
);

    de_entry_t       de_in_s;
    de_entry_t       de_q;
    em_entry_t       em_in_s;
    em_entry_t       em_q;
    logic            resolved_d;
    logic            resolved_q;
    logic            mispred_s;
    logic            branch_s;
    logic [PC_W-1:0] rpc_calc_s;
    res_state_e      state_d;
    res_state_e      state_q;
    logic [PC_W-1:0] rpc_d;
    logic [PC_W-1:0] rpc_q;

    assign de_in_s = '{valid: branchD, pred: pred_takeD, pc: pcD, target: targetD};

    bp_stage_reg #(.W($bits(de_entry_t))) u_de_reg (
        .clk   (clk),
        .rst   (rst),
        .stall (stallE),
        .flush (flushE),
        .d     (de_in_s),
        .q     (de_q)
    );

    // A held D->E register while M drains means M receives a bubble
    assign em_in_s = '{valid:  de_q.valid & ~stallE,
                       pred:   de_q.pred,
                       actual: actual_takeE,
                       pc:     de_q.pc,
                       target: de_q.target};

    bp_stage_reg #(.W($bits(em_entry_t))) u_em_reg (
        .clk   (clk),
        .rst   (rst),
        .stall (stallM),
        .flush (flushM),
        .d     (em_in_s),
        .q     (em_q)
    );

    // resolved marks an M entry that has already been checked once
    always_comb begin
        resolved_d = 1'b0;
        if (rst || flushM) begin
            resolved_d = 1'b0;
        end else if (stallM) begin
            resolved_d = em_q.valid;
        end else begin
            resolved_d = 1'b0;
        end
    end

    // resolved flag storage
    always_ff @(posedge clk) begin
        resolved_q <= resolved_d;
    end

    assign mispred_s  = em_q.valid & ~resolved_q & (em_q.pred ^ em_q.actual);
    assign branch_s   = em_q.valid & ~stallM;
    assign rpc_calc_s = em_q.actual ? em_q.target : fall_through(em_q.pc, DELAY_SLOT);

    // redirect FSM next state; PEND deliberately ignores new detections
    always_comb begin
        state_d = state_q;
        rpc_d   = rpc_q;
        if (rst) begin
            state_d = RES_IDLE;
            rpc_d   = '0;
        end else begin
            case (state_q)
                RES_IDLE: begin
                    if (mispred_s) begin
                        state_d = RES_PEND;
                        rpc_d   = rpc_calc_s;
                    end else begin
                        state_d = RES_IDLE;
                    end
                end
                RES_PEND: begin
                    if (bus.redirect_ready) begin
                        state_d = RES_IDLE;
                    end else begin
                        state_d = RES_PEND;
                    end
                end
                default: begin
                    state_d = RES_IDLE;
                end
            endcase
        end
    end

    // redirect FSM state and latched redirect PC
    always_ff @(posedge clk) begin
        state_q <= state_d;
        rpc_q   <= rpc_d;
    end

    assign mispredM           = mispred_s;
    assign flush_front        = mispred_s | (state_q == RES_PEND);
    assign bus.branchM        = branch_s;
    assign bus.actual_takeM   = em_q.actual;
    assign bus.pcM            = em_q.pc;
    assign bus.redirect_valid = mispred_s | (state_q == RES_PEND);
    assign bus.redirect_pc    = ((state_q == RES_IDLE) && mispred_s) ? rpc_calc_s : rpc_q;

`ifdef BRANCH_RESOLVE_PERF_CNT_EN
    logic [CNT_W-1:0] bcnt_d;
    logic [CNT_W-1:0] bcnt_q;
    logic [CNT_W-1:0] mcnt_d;
    logic [CNT_W-1:0] mcnt_q;

    // wrap-around event counters
    always_comb begin
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        if (rst) begin
            bcnt_d = '0;
            mcnt_d = '0;
        end else begin
            bcnt_d = bcnt_q + {{(CNT_W-1){1'b0}}, branch_s};
            mcnt_d = mcnt_q + {{(CNT_W-1){1'b0}}, mispred_s};
        end
    end

    // counter storage
    always_ff @(posedge clk) begin
        bcnt_q <= bcnt_d;
        mcnt_q <= mcnt_d;
    end

    assign branch_cnt  = bcnt_q;
    assign mispred_cnt = mcnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus random traffic,
// compared every cycle against a behavioural pipeline model (DELAY_SLOT 0 and 1 instances).
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        branchD, pred_takeD, stallE, flushE, stallM, flushM, actual_takeE, ready;
    logic [31:0] pcD, targetD;
    logic        mis0, ff0, mis1, ff1;
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
    logic [31:0] bc0, mc0, bc1, mc1;
`endif

    branch_resolve_if bus0 ();
    branch_resolve_if bus1 ();
    assign bus0.redirect_ready = ready;
    assign bus1.redirect_ready = ready;

    always #5 clk = ~clk;

    branch_resolve #(.DELAY_SLOT(1'b0), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .branchD(branchD), .pred_takeD(pred_takeD), .pcD(pcD),
        .targetD(targetD), .stallE(stallE), .flushE(flushE), .stallM(stallM),
        .flushM(flushM), .actual_takeE(actual_takeE), .mispredM(mis0), .flush_front(ff0),
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
        .branch_cnt(bc0), .mispred_cnt(mc0),
`endif
        .bus(bus0)
    );

    branch_resolve #(.DELAY_SLOT(1'b1), .CNT_W(32)) u_dut_ds (
        .clk(clk), .rst(rst), .branchD(branchD), .pred_takeD(pred_takeD), .pcD(pcD),
        .targetD(targetD), .stallE(stallE), .flushE(flushE), .stallM(stallM),
        .flushM(flushM), .actual_takeE(actual_takeE), .mispredM(mis1), .flush_front(ff1),
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
        .branch_cnt(bc1), .mispred_cnt(mc1),
`endif
        .bus(bus1)
    );

    // behavioural model: one slot per stage, age = cycles the M entry has been in M
    bit          e_v, e_p, m_v, m_p, m_a, pend;
    logic [31:0] e_pc, e_tg, m_pc, m_tg, ppc0, ppc1, mb, mm;
    int          m_age;

    int n_pass = 0, n_tot = 0;
    int n_br = 0, n_mis = 0, n_rv = 0, n_ff = 0;
    bit cmp_en = 1'b0;
    logic        s_br, s_act, s_mis, s_rv, s_ff;
    logic [31:0] s_pc, s_rpc0, s_rpc1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic bit exp_mis();
        return m_v && (m_age == 0) && (m_p != m_a);
    endfunction

    function automatic logic [31:0] calc(input bit ds);
        return m_a ? m_tg : (m_pc + (ds ? 32'd8 : 32'd4));
    endfunction

    task automatic model_update();
        bit mis;
        mis = exp_mis();
        if (rst) begin
            e_v = 1'b0; e_p = 1'b0; e_pc = 32'd0; e_tg = 32'd0;
            m_v = 1'b0; m_p = 1'b0; m_a = 1'b0; m_pc = 32'd0; m_tg = 32'd0; m_age = 0;
            pend = 1'b0; ppc0 = 32'd0; ppc1 = 32'd0; mb = 32'd0; mm = 32'd0;
        end else begin
            if (pend) begin
                if (ready) pend = 1'b0;
            end else if (mis) begin
                pend = 1'b1; ppc0 = calc(1'b0); ppc1 = calc(1'b1);
            end
            if (m_v && !stallM) mb = mb + 32'd1;
            if (mis) mm = mm + 32'd1;
            if (flushM) begin
                m_v = 1'b0; m_p = 1'b0; m_a = 1'b0; m_pc = 32'd0; m_tg = 32'd0; m_age = 0;
            end else if (!stallM) begin
                m_v = e_v && !stallE; m_p = e_p; m_a = actual_takeE;
                m_pc = e_pc; m_tg = e_tg; m_age = 0;
            end else begin
                m_age++;
            end
            if (flushE) begin
                e_v = 1'b0; e_p = 1'b0;
            end else if (!stallE) begin
                e_v = branchD; e_p = pred_takeD; e_pc = pcD; e_tg = targetD;
            end
        end
    endtask

    // one clock: compare on the falling edge, advance the model on the rising edge
    task automatic cyc();
        bit mis;
        @(negedge clk);
        s_br = bus0.branchM; s_act = bus0.actual_takeM; s_pc = bus0.pcM; s_mis = mis0;
        s_rv = bus0.redirect_valid; s_ff = ff0; s_rpc0 = bus0.redirect_pc; s_rpc1 = bus1.redirect_pc;
        if (cmp_en) begin
            mis = exp_mis();
            chk("branchM", bus0.branchM, m_v && !stallM);
            if (m_v) begin
                chk("actual_takeM", bus0.actual_takeM, m_a);
                chk("pcM", bus0.pcM, m_pc);
            end
            chk("mispredM", mis0, mis);
            chk("mispredM_ds", mis1, mis);
            chk("redirect_valid", bus0.redirect_valid, pend || mis);
            chk("flush_front", ff0, pend || mis);
            chk("redirect_pc", bus0.redirect_pc, (!pend && mis) ? calc(1'b0) : ppc0);
            chk("redirect_pc_ds", bus1.redirect_pc, (!pend && mis) ? calc(1'b1) : ppc1);
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
            chk("branch_cnt", bc0, mb);
            chk("mispred_cnt", mc0, mm);
`endif
            if (bus0.branchM) n_br++;
            if (mis0) n_mis++;
            if (bus0.redirect_valid) n_rv++;
            if (ff0) n_ff++;
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        branchD = 1'b0; pred_takeD = 1'b0; pcD = 32'd0; targetD = 32'd0;
        stallE = 1'b0; flushE = 1'b0; stallM = 1'b0; flushM = 1'b0;
        actual_takeE = 1'b0; ready = 1'b0;
    endtask

    // drive one branch through D and E; returns with it sitting in M for the next cyc()
    task automatic issue(input bit pred, input bit act, input logic [31:0] pc, input logic [31:0] tg);
        branchD = 1'b1; pred_takeD = pred; pcD = pc; targetD = tg;
        cyc();
        branchD = 1'b0; pred_takeD = 1'b0; actual_takeE = act;
        cyc();
        actual_takeE = 1'b0;
    endtask

    initial begin
        int b_br, b_mis, b_rv, b_ff;
        rst = 1'b1;
        idle_inputs();
        cyc();
        cmp_en = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("reset_branchM", s_br, 1'b0);
        chk("reset_pcM", s_pc, 32'd0);
        chk("reset_redirect_valid", s_rv, 1'b0);
        chk("reset_redirect_pc", s_rpc0, 32'd0);
        chk("reset_flush_front", s_ff, 1'b0);

        // correct taken prediction
        issue(1'b1, 1'b1, 32'h100, 32'h200);
        cyc();
        chk("t1_branchM", s_br, 1'b1);
        chk("t1_actual", s_act, 1'b1);
        chk("t1_pcM", s_pc, 32'h100);
        chk("t1_mispred", s_mis, 1'b0);
        chk("t1_rvalid", s_rv, 1'b0);
        repeat (2) cyc();

        // predicted taken, not taken; fetch accepts one cycle later
        b_mis = n_mis; b_rv = n_rv; b_ff = n_ff;
        issue(1'b1, 1'b0, 32'h40, 32'h300);
        cyc();
        chk("t2_mispred", s_mis, 1'b1);
        chk("t2_redirect_pc", s_rpc0, 32'h44);
        ready = 1'b1;
        cyc();
        chk("t2_rvalid_hold", s_rv, 1'b1);
        ready = 1'b0;
        cyc();
        chk("t2_rvalid_drop", s_rv, 1'b0);
        repeat (2) cyc();
        chk("t2_mispred_cycles", n_mis - b_mis, 1);
        chk("t2_rvalid_cycles", n_rv - b_rv, 2);
        chk("t2_flush_cycles", n_ff - b_ff, 2);

        // predicted not taken, taken, stalled in M for 3 cycles, then slow fetch
        b_mis = n_mis; b_br = n_br;
        issue(1'b0, 1'b1, 32'h60, 32'h80);
        stallM = 1'b1;
        repeat (3) cyc();
        stallM = 1'b0;
        cyc();
        chk("t3_branch_on_release", s_br, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_rvalid_stable", s_rv, 1'b1);
            chk("t4_rpc_stable", s_rpc0, 32'h80);
        end
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        cyc();
        chk("t4_idle_after_ready", s_rv, 1'b0);
        chk("t3_mispred_pulses", n_mis - b_mis, 1);
        chk("t3_branch_pulses", n_br - b_br, 1);

        // flushE squashes a branch in D
        b_mis = n_mis; b_br = n_br;
        branchD = 1'b1; pred_takeD = 1'b1; pcD = 32'h700; targetD = 32'h800; flushE = 1'b1;
        cyc();
        branchD = 1'b0; flushE = 1'b0; actual_takeE = 1'b0;
        repeat (4) cyc();
        chk("t5_no_branch", n_br - b_br, 0);
        chk("t5_no_mispred", n_mis - b_mis, 0);

        // reset while a redirect is pending
        issue(1'b0, 1'b1, 32'h500, 32'h900);
        cyc();
        cyc();
        chk("t6_pend_before_rst", s_rv, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("t6_rvalid_after_rst", s_rv, 1'b0);
        chk("t6_rpc_after_rst", s_rpc0, 32'd0);
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
        chk("t6_branch_cnt_rst", bc0, 32'd0);
        chk("t6_mispred_cnt_rst", mc0, 32'd0);
`endif

        // ten branches, three mispredicted
        b_mis = n_mis; b_br = n_br;
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue(1'b1, !((i % 3) == 0 && i < 9), 32'h1000 + 32'(16 * i), 32'h2000);
            repeat (3) cyc();
        end
        ready = 1'b0;
        chk("perf_branches", n_br - b_br, 10);
        chk("perf_mispreds", n_mis - b_mis, 3);
`ifdef BRANCH_RESOLVE_PERF_CNT_EN
        chk("perf_branch_cnt", bc0, 32'd10);
        chk("perf_mispred_cnt", mc0, 32'd3);
`endif

        // fall-through wrap at the top of the address space
        issue(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h10);
        cyc();
        chk("wrap_rpc_ds0", s_rpc0, 32'h0000_0000);
        chk("wrap_rpc_ds1", s_rpc1, 32'h0000_0004);
        ready = 1'b1;
        repeat (2) cyc();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            branchD      = 1'($urandom_range(0, 1));
            pred_takeD   = 1'($urandom_range(0, 1));
            pcD          = $urandom;
            targetD      = $urandom;
            stallE       = ($urandom_range(0, 4) == 0);
            flushE       = ($urandom_range(0, 19) == 0);
            stallM       = ($urandom_range(0, 4) == 0);
            flushM       = ($urandom_range(0, 19) == 0);
            actual_takeE = 1'($urandom_range(0, 1));
            ready        = ($urandom_range(0, 2) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Resolves branches in the M stage. It is the consumer end of the gshare predictor interface.
- It carries each decode-stage prediction through E and M, compares the prediction against the actual outcome, and drives the predictor update signals (branchM, actual_takeM, pcM).
- On a mispredict it raises a front-end redirect with a valid/ready handshake and flushes the younger stages.
- Sits between the execute comparator, the fetch PC mux, and the hazard unit.

Parameters:
- DELAY_SLOT, 0: 1 means the fall-through PC is pc+8; 0 means pc+4.
- CNT_W, 32: width of the performance counters.

Ports:
- clk input 1: clock.
- rst input 1: synchronous, active-high reset.
- branchD input 1: the D-stage instruction is a conditional branch.
- pred_takeD input 1: prediction for the D-stage instruction.
- pcD input 32: PC of the D-stage instruction.
- targetD input 32: computed branch target.
- stallE input 1: hold the D->E register.
- flushE input 1: clear the D->E register.
- stallM input 1: hold the E->M register.
- flushM input 1: clear the E->M register.
- actual_takeE input 1: branch condition result from the E comparator.
- redirect_ready input 1: fetch accepts the redirect this cycle.
- branchM output 1: one-cycle predictor update strobe.
- actual_takeM output 1: resolved direction.
- pcM output 32: PC of the resolving branch.
- mispredM output 1: a mispredict is detected this cycle.
- redirect_valid output 1: a redirect request is pending.
- redirect_pc output 32: corrected fetch PC.
- flush_front output 1: flush the F/D and D/E stages.
- branch_cnt output CNT_W: number of resolved branches (only with PERF_CNT_EN).
- mispred_cnt output CNT_W: number of mispredicts (only with PERF_CNT_EN).

Behaviour:
- D->E register holds {valid, pred, pc, target}. It loads from the D inputs when ~stallE. flushE or rst clears valid and pred.
- E->M register holds {valid, pred, actual, pc, target, resolved}. It loads when ~stallM, with actual taken from actual_takeE. flushM or rst clears it. On stallE & ~stallM a bubble enters M (valid=0).
- resolved is set on the first cycle a valid entry sits in M and is held while stallM. This gives exactly one mispredict detection per branch under stall.
- mispredM = validM & ~resolved & (predM != actualM).
- branchM = validM & ~stallM, so the predictor updates exactly once, on the cycle the branch leaves M.
- actual_takeM and pcM are direct register outputs.
- redirect_pc = actualM ? targetM : pcM + (DELAY_SLOT ? 8 : 4), computed with 32-bit wrap-around arithmetic. The value is latched on detection.
- State machine (encoding in the package):
  - IDLE: on mispredM go to PEND, latch redirect_pc, set redirect_valid=1.
  - PEND: redirect_valid=1 and redirect_pc stays stable. When redirect_ready is seen, go to IDLE, with redirect_valid=0 in the next cycle.
  - PEND ignores further detections. This cannot legally happen, because flush_front empties D/E.
- flush_front = mispredM | (state==PEND). It is combinational.
- Reset values: all outputs are 0, the state is IDLE, and both pipeline registers are invalid.
- rst while in PEND drops the redirect request the same cycle the reset is sampled.
- mispredM and redirect_ready asserted in the same IDLE cycle: the unit still enters PEND, because ready is only honoured in PEND.

Optional Feature:
- Macro BRANCH_RESOLVE_PERF_CNT_EN.
- Defined: branch_cnt increments on each branchM. mispred_cnt increments on each mispredM. Both counters wrap modulo 2^CNT_W and are cleared by rst.
- Undefined: the counter ports and registers are absent.

Decomposition:
- branch_pkg holds:
  - the state encodings RES_IDLE=1'b0 and RES_PEND=1'b1;
  - the 2-bit counter encodings shared with the predictor (SNT=00, WNT=01, WT=11, ST=10);
  - the constants INSN_BYTES=4 and PC_W=32.
- Sub-module bp_stage_reg is a parameterised-width pipeline register with stall/flush priority: rst > flush > ~stall load. It is instantiated twice, for D->E and E->M.

Test Plan:
- Correct taken prediction. Stimulus: branchD=1, pred=1, pcD=0x100, targetD=0x200, actual_takeE=1, no stalls. Required response:
  - two cycles later branchM=1, actual_takeM=1, pcM=0x100;
  - mispredM=0 and redirect_valid=0.
- Predicted taken, actually not taken, pcD=0x40, DELAY_SLOT=0, redirect_ready=1 one cycle later. Required response:
  - mispredM=1 for 1 cycle;
  - redirect_pc=0x44;
  - redirect_valid high for 2 cycles;
  - flush_front high for 2 cycles.
- Predicted not taken, actually taken, targetD=0x80, with stallM held 3 cycles while in M. Required response:
  - mispredM pulses once;
  - branchM pulses once, on release;
  - redirect_pc=0x80.
- redirect_ready held low 5 cycles in PEND. Required response: redirect_valid and redirect_pc=0x80 stable throughout; IDLE one cycle after ready.
- flushE asserted the same cycle a branch is in D. Required response: no branchM and no mispredM for it. With PERF_CNT_EN, after 10 resolved branches including 3 mispredicts, branch_cnt=10 and mispred_cnt=3.
- rst in PEND, and pcD=0xFFFFFFFC not taken with DELAY_SLOT=1. Required response:
  - rst in PEND: redirect_valid=0 the next cycle, all counters 0.
  - 0xFFFFFFFC case: redirect_pc wraps to 0x00000004.
